decoder_ham: RTL and testbench
==============================

// Module: decoder_ham
// PURPOSE
//  Hamming(21,16) single-error-correcting decoder; receive end of the 21-bit coded link.
//  Accepts 21-bit codewords, computes the 5-bit syndrome, corrects any single-bit error
//  and delivers the 16-bit payload with error flags.
//  Two-stage registered pipeline with valid/ready flow control and full backpressure.
// PARAMETERS
//  CNT_W  16  width of the error statistics counters (only with DEC_HAM_STAT_EN)
// PORTS
//  clk_i        in   1      single clock, rising edge
//  rst_i        in   1      synchronous reset, active-low (0 = reset)
//  dat_i        in   21     codeword; bit k = Hamming position k+1
//  vld_i        in   1      dat_i valid
//  rdy_o        out  1      decoder can accept dat_i this cycle
//  dat_o        out  16     corrected payload
//  err_o        out  1      single error corrected (data or check bit)
//  unc_o        out  1      uncorrectable: syndrome 22..31; dat_o = raw data bits
//  vld_o        out  1      dat_o/err_o/unc_o valid
//  rdy_i        in   1      downstream accepts
//  clr_i        in   1      clear statistics counters (DEC_HAM_STAT_EN only)
//  corr_cnt_o   out  CNT_W  count of err_o words (DEC_HAM_STAT_EN only)
//  unc_cnt_o    out  CNT_W  count of unc_o words (DEC_HAM_STAT_EN only)
// BEHAVIOUR
//  - Codeword layout, LSB first: c0 c1 d0 c2 d1..d3 c3 d4..d10 c4 d11..d15.
//    Check bits at positions 1,2,4,8,16 (dat_i[0],[1],[3],[7],[15]).
//  - Syndrome s[i] = XOR of all dat_i[k] with bit i of (k+1) set, i = 0..4.
//  - s == 0: pass the data bits unchanged; err_o = 0, unc_o = 0.
//  - s in 1..21: invert dat_i[s-1], then extract data; err_o = 1.
//    s in {1,2,4,8,16}: the flipped bit is a check bit, so the payload is unchanged
//    but err_o is still 1.
//  - s in 22..31: no flip; unc_o = 1, err_o = 0.
//  - A double error can alias to s in 1..21 and be miscorrected; accepted limitation.
//  - Stage 1 registers the codeword and syndrome; stage 2 registers the corrected word
//    and the flags. Latency from input handshake to vld_o is 2 clk_i cycles.
//  - Handshake:
//      * A transfer occurs when vld and rdy are both high on a rising edge.
//      * s2_adv = !vld_o | rdy_i; s1_adv = !s1_vld | s2_adv; rdy_o = s1_adv (combinational).
//      * Sustained throughput is 1 word/cycle when rdy_i = 1.
//  - While vld_o = 1 and rdy_i = 0, dat_o, err_o, unc_o and vld_o hold stable.
//    Stage 1 keeps its word, and rdy_o drops once stage 1 is full.
//  - vld_o never deasserts without a transfer. No word is lost or duplicated.
//  - Reset (rst_i = 0 at a clock edge) empties both stages regardless of traffic in flight:
//      * vld_o = 0, dat_o = 0, err_o = 0, unc_o = 0, stage 1 valid = 0.
//      * rdy_o = 0 while rst_i = 0; rdy_o = 1 in the first cycle after release.
// CONFIGURATION
//  - DEC_HAM_STAT_EN defined:
//      * corr_cnt_o increments on each output transfer with err_o = 1.
//      * unc_cnt_o increments on each output transfer with unc_o = 1.
//      * Both counters saturate at 2^CNT_W-1 and reset to 0.
//      * clr_i = 1 zeroes both counters; clr_i has priority over a same-cycle increment.
//  - DEC_HAM_STAT_EN undefined: clr_i, corr_cnt_o and unc_cnt_o are absent from the port
//    list, and no counter logic is built.
// TESTING
//  - Clean word: payload 16'hA5C3 encoded -> dat_o = 16'hA5C3, err_o = 0, unc_o = 0,
//    2 cycles after the input handshake.
//  - Data-bit error: codeword for 16'h1234 with dat_i[2] (d0) flipped -> dat_o = 16'h1234,
//    err_o = 1; repeat for all 21 single-bit positions.
//  - Check-bit error: flip dat_i[7] (s = 8) on payload 16'hFFFF -> dat_o = 16'hFFFF, err_o = 1.
//  - Uncorrectable: flip dat_i[20] and dat_i[1] of the zero codeword (s = 21^2 = 23)
//    -> unc_o = 1, err_o = 0.
//  - Backpressure: stream 8 words with rdy_i toggling 1,0,0,1,...
//    -> in-order output, outputs stable while stalled, rdy_o = 0 when both stages are full.
//  - Reset mid-stream: rst_i = 0 for 1 cycle with both stages full -> next cycle vld_o = 0,
//    the in-flight words are dropped, and rdy_o = 1 after release.
//  - Statistics (DEC_HAM_STAT_EN, CNT_W = 2): 5 corrected words -> corr_cnt_o saturates at 3;
//    clr_i pulse -> 0.

Source files
------------

// File: rtl/decoder_ham_if.sv
// Stream bundle for the Hamming(21,16) decoder: coded input side and decoded output side.
// The decoder uses the slave modport; the source/sink driving it uses master.
interface decoder_ham_if;
  logic [20:0] dat_i;
  logic        vld_i;
  logic        rdy_o;
  logic [15:0] dat_o;
  logic        err_o;
  logic        unc_o;
  logic        vld_o;
  logic        rdy_i;

  modport slave (
    input  dat_i, vld_i, rdy_i,
    output rdy_o, dat_o, err_o, unc_o, vld_o
  );

  modport master (
    output dat_i, vld_i, rdy_i,
    input  rdy_o, dat_o, err_o, unc_o, vld_o
  );
endinterface

// File: rtl/decoder_ham.sv
// Hamming(21,16) SEC decoder, two-stage valid/ready pipeline with full backpressure.
// Define DEC_HAM_STAT_EN to build the saturating corrected/uncorrectable word counters.
module decoder_ham
`ifdef DEC_HAM_STAT_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic             clk_i,
  input  logic             rst_i,
  decoder_ham_if.slave     stream_io
`ifdef DEC_HAM_STAT_EN
  ,
  input  logic             clr_i,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] unc_cnt_o
`endif
);

  logic        s1_vld_q;
  logic [20:0] s1_cw_q;
  logic [4:0]  s1_syn_q;
  logic [4:0]  s1_syn_d;

  logic        vld_q;
  logic [15:0] dat_q;
  logic        err_q;
  logic        unc_q;

  logic [20:0] fix_cw;
  logic [15:0] fix_dat;
  logic        fix_err;
  logic        fix_unc;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv = ~vld_q | stream_io.rdy_i;
  assign s1_adv = ~s1_vld_q | s2_adv;

  // Syndrome bit i covers every position whose 1-based index has bit i set.
  always_comb begin
    s1_syn_d = '0;
    for (int k = 0; k < 21; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (((k + 1) & (1 << i)) != 0) begin
          s1_syn_d[i] = s1_syn_d[i] ^ stream_io.dat_i[k];
        end
      end
    end
  end

  always_comb begin
    fix_cw  = s1_cw_q;
    fix_err = 1'b0;
    fix_unc = 1'b0;
    if (s1_syn_q == 5'd0) begin
      fix_cw = s1_cw_q;
    end else if (s1_syn_q <= 5'd21) begin
      fix_cw  = s1_cw_q ^ (21'd1 << (s1_syn_q - 5'd1));
      fix_err = 1'b1;
    end else begin
      fix_unc = 1'b1;
    end
  end

  assign fix_dat = {fix_cw[20:16], fix_cw[14:8], fix_cw[6:4], fix_cw[2]};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_vld_q <= 1'b0;
      s1_cw_q  <= '0;
      s1_syn_q <= '0;
      vld_q    <= 1'b0;
      dat_q    <= '0;
      err_q    <= 1'b0;
      unc_q    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= stream_io.vld_i;
        if (stream_io.vld_i) begin
          s1_cw_q  <= stream_io.dat_i;
          s1_syn_q <= s1_syn_d;
        end
      end
      if (s2_adv) begin
        vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          dat_q <= fix_dat;
          err_q <= fix_err;
          unc_q <= fix_unc;
        end
      end
    end
  end

  // rdy_o is forced low during reset so no word is accepted into a stage being cleared.
  assign stream_io.rdy_o = rst_i & s1_adv;
  assign stream_io.dat_o = dat_q;
  assign stream_io.err_o = err_q;
  assign stream_io.unc_o = unc_q;
  assign stream_io.vld_o = vld_q;

`ifdef DEC_HAM_STAT_EN
  logic             out_xfer;
  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] unc_cnt_q;

  assign out_xfer = vld_q & stream_io.rdy_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i || clr_i) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      if (out_xfer && err_q && (corr_cnt_q != '1)) begin
        corr_cnt_q <= corr_cnt_q + 1'b1;
      end
      if (out_xfer && unc_q && (unc_cnt_q != '1)) begin
        unc_cnt_q <= unc_cnt_q + 1'b1;
      end
    end
  end

  assign corr_cnt_o = corr_cnt_q;
  assign unc_cnt_o  = unc_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_ham.sv
// Self-checking bench for decoder_ham: directed error patterns plus a randomized stream
// scored against an arithmetic Hamming model.
module tb_decoder_ham;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decoder_ham_if bus_if ();

`ifdef DEC_HAM_STAT_EN
  logic       clr = 1'b0;
  logic [1:0] corr_cnt;
  logic [1:0] unc_cnt;
  decoder_ham #(.CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .stream_io(bus_if),
    .clr_i(clr), .corr_cnt_o(corr_cnt), .unc_cnt_o(unc_cnt)
  );
`else
  decoder_ham dut (.clk_i(clk), .rst_i(rst), .stream_io(bus_if));
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [20:0] encode(input logic [15:0] d);
    logic [20:0] c;
    int j;
    logic par;
    c = '0;
    j = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      par = 1'b0;
      for (int p = 1; p <= 21; p++) if (((p >> i) & 1) == 1) par ^= c[p-1];
      c[(1 << i) - 1] = par;
    end
    return c;
  endfunction

  // Returns {data, err, unc}; syndrome is the XOR of the indices of all set bits.
  function automatic logic [17:0] model(input logic [20:0] cw);
    logic [20:0] c;
    logic [15:0] d;
    int s;
    int j;
    logic e;
    logic u;
    c = cw;
    s = 0;
    e = 1'b0;
    u = 1'b0;
    for (int p = 1; p <= 21; p++) if (c[p-1]) s = s ^ p;
    if (s >= 1 && s <= 21) begin
      c[s-1] = ~c[s-1];
      e = 1'b1;
    end else if (s > 21) begin
      u = 1'b1;
    end
    j = 0;
    d = '0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return {d, e, u};
  endfunction

  function automatic logic [20:0] rand_cw();
    logic [20:0] c;
    int kind;
    c = encode(16'($urandom));
    kind = $urandom_range(0, 3);
    if (kind == 1) begin
      c[$urandom_range(0, 20)] ^= 1'b1;
    end else if (kind == 2) begin
      c[$urandom_range(0, 20)] ^= 1'b1;
      c[$urandom_range(0, 20)] ^= 1'b1;
    end else if (kind == 3) begin
      c = 21'($urandom);
    end
    return c;
  endfunction

  task automatic drive_idle();
    bus_if.dat_i = '0;
    bus_if.vld_i = 1'b0;
    bus_if.rdy_i = 1'b1;
  endtask

  // Pushes one word into an empty pipeline; returns at the negedge where vld_o is seen.
  task automatic send_one(input logic [20:0] cw, output logic [15:0] d, output logic e,
                          output logic u, output int lat, output logic seen);
    int n;
    @(posedge clk);
    #1;
    bus_if.dat_i = cw;
    bus_if.vld_i = 1'b1;
    bus_if.rdy_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus_if.rdy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus_if.vld_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus_if.vld_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    seen = bus_if.vld_o;
    d    = bus_if.dat_o;
    e    = bus_if.err_o;
    u    = bus_if.unc_o;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (bus_if.vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus_if.vld_o); end
    if (bus_if.dat_o !== 16'h0) begin errors++; $display("FAIL reset_dat: got %h want 0000", bus_if.dat_o); end
    if (bus_if.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_if.err_o); end
    if (bus_if.unc_o !== 1'b0) begin errors++; $display("FAIL reset_unc: got %b want 0", bus_if.unc_o); end
    if (bus_if.rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy_low: got %b want 0", bus_if.rdy_o); end
`ifdef DEC_HAM_STAT_EN
    checks++;
    if (corr_cnt !== 2'd0 || unc_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", corr_cnt, unc_cnt);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy_release: got %b want 1", bus_if.rdy_o); end
  endtask

  task automatic test_clean();
    logic [15:0] d; logic e, u, seen; int lat;
    send_one(encode(16'hA5C3), d, e, u, lat, seen);
    checks += 4;
    if (!seen || lat != 2) begin errors++; $display("FAIL clean_latency: got %0d want 2", lat); end
    if (d !== 16'hA5C3) begin errors++; $display("FAIL clean_dat: got %h want a5c3", d); end
    if (e !== 1'b0) begin errors++; $display("FAIL clean_err: got %b want 0", e); end
    if (u !== 1'b0) begin errors++; $display("FAIL clean_unc: got %b want 0", u); end
  endtask

  task automatic test_single_errors();
    logic [15:0] d; logic e, u, seen; int lat;
    logic [20:0] cw;
    for (int p = 0; p < 21; p++) begin
      cw = encode(16'h1234);
      cw[p] = ~cw[p];
      send_one(cw, d, e, u, lat, seen);
      checks++;
      if (!seen || d !== 16'h1234 || e !== 1'b1 || u !== 1'b0) begin
        errors++;
        $display("FAIL single_bit%0d: got vld=%b dat=%h err=%b unc=%b want vld=1 dat=1234 err=1 unc=0",
                 p, seen, d, e, u);
      end
    end
    cw = encode(16'hFFFF);
    cw[7] = ~cw[7];
    send_one(cw, d, e, u, lat, seen);
    checks++;
    if (!seen || d !== 16'hFFFF || e !== 1'b1 || u !== 1'b0) begin
      errors++;
      $display("FAIL check_bit8: got dat=%h err=%b unc=%b want dat=ffff err=1 unc=0", d, e, u);
    end
  endtask

  task automatic test_uncorrectable();
    logic [15:0] d; logic e, u, seen; int lat;
    logic [20:0] cw;
    cw = '0;
    cw[20] = 1'b1;
    cw[1] = 1'b1;
    send_one(cw, d, e, u, lat, seen);
    checks += 2;
    if (!seen || u !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL unc_flags: got unc=%b err=%b want unc=1 err=0", u, e);
    end
    if (d !== 16'h8000) begin errors++; $display("FAIL unc_raw_dat: got %h want 8000", d); end
  endtask

  task automatic run_stream(input int nwords, input bit bp_pattern, input string name);
    logic [17:0] exp_q[$];
    logic [17:0] exp_w;
    logic [17:0] held;
    logic [3:0]  pat;
    bit push, pop, stalled, exp_rdy;
    int occ, sent, received, cyc;
    pat = 4'b1001;
    occ = 0; sent = 0; received = 0; cyc = 0; stalled = 1'b0; held = '0;
    @(posedge clk);
    #1;
    bus_if.dat_i = rand_cw();
    bus_if.vld_i = 1'b1;
    bus_if.rdy_i = bp_pattern ? pat[0] : ($urandom_range(0, 2) != 0);
    while (received < nwords && cyc < 4000) begin
      @(negedge clk);
      push = bus_if.vld_i && bus_if.rdy_o;
      pop  = bus_if.vld_o && bus_if.rdy_i;
      exp_rdy = !(occ == 2 && !bus_if.rdy_i);
      checks++;
      if (bus_if.rdy_o !== exp_rdy) begin
        errors++; $display("FAIL %s_rdy cyc %0d: got %b want %b", name, cyc, bus_if.rdy_o, exp_rdy);
      end
      if (stalled) begin
        checks++;
        if (bus_if.vld_o !== 1'b1 || {bus_if.dat_o, bus_if.err_o, bus_if.unc_o} !== held) begin
          errors++;
          $display("FAIL %s_hold cyc %0d: got vld=%b out=%h want vld=1 out=%h", name, cyc,
                   bus_if.vld_o, {bus_if.dat_o, bus_if.err_o, bus_if.unc_o}, held);
        end
      end
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_extra cyc %0d: got unexpected word %h want none", name, cyc,
                             bus_if.dat_o);
        end else begin
          exp_w = exp_q.pop_front();
          if ({bus_if.dat_o, bus_if.err_o, bus_if.unc_o} !== exp_w) begin
            errors++;
            $display("FAIL %s_word %0d: got dat=%h err=%b unc=%b want dat=%h err=%b unc=%b", name,
                     received, bus_if.dat_o, bus_if.err_o, bus_if.unc_o, exp_w[17:2], exp_w[1],
                     exp_w[0]);
          end
        end
        received++;
      end
      stalled = bus_if.vld_o && !bus_if.rdy_i;
      held = {bus_if.dat_o, bus_if.err_o, bus_if.unc_o};
      if (push) begin
        exp_q.push_back(model(bus_if.dat_i));
        sent++;
      end
      occ = occ + int'(push) - int'(pop);
      cyc++;
      @(posedge clk);
      #1;
      if (push || !bus_if.vld_i) begin
        if (sent < nwords) begin
          bus_if.dat_i = rand_cw();
          bus_if.vld_i = bp_pattern ? 1'b1 : ($urandom_range(0, 3) != 0);
        end else begin
          bus_if.vld_i = 1'b0;
        end
      end
      bus_if.rdy_i = bp_pattern ? pat[cyc % 4] : ($urandom_range(0, 2) != 0);
    end
    checks++;
    if (received != nwords) begin
      errors++; $display("FAIL %s_timeout: got %0d words want %0d", name, received, nwords);
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    run_stream(8, 1'b1, "backpressure");
  endtask

  task automatic test_random_stream();
    run_stream(300, 1'b0, "random");
  endtask

  task automatic test_reset_midstream();
    int seen_vld;
    @(posedge clk);
    #1;
    bus_if.rdy_i = 1'b0;
    bus_if.vld_i = 1'b1;
    bus_if.dat_i = encode(16'h0F0F);
    repeat (3) @(posedge clk);
    #1 bus_if.vld_i = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus_if.rdy_o !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b want 0", bus_if.rdy_o); end
    if (bus_if.vld_o !== 1'b1) begin errors++; $display("FAIL full_vld: got %b want 1", bus_if.vld_o); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus_if.vld_o !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b want 0", bus_if.vld_o); end
    if (bus_if.rdy_o !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b want 1", bus_if.rdy_o); end
    bus_if.rdy_i = 1'b1;
    seen_vld = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.vld_o) seen_vld++;
    end
    checks++;
    if (seen_vld != 0) begin errors++; $display("FAIL midrst_drop: got %0d words want 0", seen_vld); end
  endtask

`ifdef DEC_HAM_STAT_EN
  task automatic test_stats();
    logic [15:0] d; logic e, u, seen; int lat;
    logic [20:0] cw;
    for (int n = 0; n < 5; n++) begin
      cw = encode(16'($urandom));
      cw[n] = ~cw[n];
      send_one(cw, d, e, u, lat, seen);
    end
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (corr_cnt !== 2'd3) begin errors++; $display("FAIL stat_corr_sat: got %0d want 3", corr_cnt); end
    if (unc_cnt !== 2'd0) begin errors++; $display("FAIL stat_unc_zero: got %0d want 0", unc_cnt); end
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checks++;
    if (corr_cnt !== 2'd0) begin errors++; $display("FAIL stat_clr: got %0d want 0", corr_cnt); end
    cw = '0;
    cw[20] = 1'b1;
    cw[1] = 1'b1;
    send_one(cw, d, e, u, lat, seen);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (unc_cnt !== 2'd1) begin errors++; $display("FAIL stat_unc: got %0d want 1", unc_cnt); end
  endtask
`endif

  initial begin
    drive_idle();
    test_reset();
    test_clean();
    test_single_errors();
    test_uncorrectable();
    test_backpressure();
    test_random_stream();
    test_reset_midstream();
`ifdef DEC_HAM_STAT_EN
    test_stats();
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want summary");
    $fatal(1, "watchdog expired");
  end

endmodule
